spi_slave_sync: RTL and testbench
=================================

Name: spi_slave_sync

Overview:
Fully synchronous SPI slave (responder) that runs on the system clock and oversamples the serial pins.
- It is the responder counterpart to spi_master, replacing the sclk-clocked spi_slave wherever the attached logic lives in the system clock domain.
- Deserialises MOSI into parallel bytes and serialises a locally supplied byte onto MISO.
- Mode 0 (CPOL=0, CPHA=0), MSB first.

Parameters:
WIDTH, 8, bits per SPI word / parallel data width
DEFAULT_TX, 8'h00, word shifted out when no tx word is loaded at word start (width WIDTH)
SYNC_STAGES, 2, synchroniser flops on sclk, ss and mosi (minimum 2)

Ports:
clk  input  1  system clock; must be at least 4x the sclk frequency
rst  input  1  synchronous, active-high reset
sclk  input  1  SPI serial clock from master, asynchronous to clk
ss  input  1  slave select, active low, asynchronous
mosi  input  1  master-out serial data
miso  output  1  slave-out serial data; 0 while deselected
miso_oe  output  1  high while selected; enable for an external tristate
tx_data  input  WIDTH  word to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  tx holding register empty
rx_data  output  WIDTH  last completely received word
rx_valid  output  1  one-cycle pulse, rx_data updated
tx_underrun  output  1  one-cycle pulse, word started with no tx word loaded
busy  output  1  high from select until deselect

Behaviour:
Clocking and reset
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the clk rising edge.
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0.
- Reset also clears the shift registers and bit counter, empties the holding register, returns the FSM to IDLE and sets all synchroniser flops to idle levels (sclk=0, ss=1, mosi=0).

Synchronisation and edge detection
- sclk, ss and mosi each pass through SYNC_STAGES flops.
- A further registered copy of synchronised sclk and ss gives edge detection: sclk_rise, sclk_fall, ss_fall, ss_rise.

TX holding register
- A handshake completes when tx_valid && tx_ready. tx_data is captured and tx_ready drops the next cycle.
- tx_ready returns high the cycle after the holding register is copied into the tx shift register.

FSM
- IDLE -> ACTIVE on ss_fall.
  - Load the tx shift register from the holding register (or DEFAULT_TX plus a tx_underrun pulse if empty).
  - bit_cnt=0, busy=1, miso_oe=1, miso=shift MSB.
- ACTIVE, sclk_rise: rx_shift = {rx_shift[WIDTH-2:0], mosi_sync}; bit_cnt++.
- Word completion: when bit_cnt reaches WIDTH on a rise, the next cycle sets rx_data to the new word, pulses rx_valid for 1 cycle, and resets bit_cnt to 0.
- ACTIVE, sclk_fall:
  - bit_cnt != 0: shift tx left and present the next bit on miso.
  - bit_cnt == 0 (word boundary): reload tx shift from the holding register (or DEFAULT_TX plus tx_underrun), so back-to-back words need no deselect.
- ACTIVE -> IDLE on ss_rise.
  - Partial rx word discarded; no rx_valid.
  - bit_cnt=0, busy=0, miso=0, miso_oe=0.
  - The holding register keeps any unconsumed word.

Latency and edge cases
- rx_valid rises at most SYNC_STAGES+2 clk cycles after the WIDTH-th sclk rising edge at the pin.
- Simultaneous handshake and shift-register load in the same cycle: the load takes the old holding content (or DEFAULT_TX if empty), and the new word stays held.
- sclk edges while ss is high are ignored.
- ss_fall and sclk_rise in the same cycle: select is processed first, and the sclk edge is dropped (master timing violation).
- No overrun flag: the local side must consume rx_data within one word time.

Decomposition:
- Shared package spi_pkg: SPI_WIDTH=8, DEFAULT_TX, and the FSM state enum (IDLE, ACTIVE) shared with spi_master.
- One natural sub-module: spi_sync_edge (SYNC_STAGES-deep synchroniser plus rise/fall detector), instantiated three times; only the sclk and ss instances use the edge outputs.

Test Plan:
1. Reset: hold rst for 3 clk -> all outputs at reset values, tx_ready=1. Then drive ss, sclk and mosi activity during rst -> no rx_valid and no miso activity.
2. Single word, clk = 8x sclk:
   - Load tx 8'hA5, then master sends 8'b11101010.
   - rx_data=8'hEA with one rx_valid pulse; master samples 8'hA5.
   - tx_ready low after the handshake, high again after ss_fall.
3. Back-to-back: load 8'h3C, then 8'hC3 while the first word is shifting; ss held low for 16 sclk.
   - Master receives 8'h3C then 8'hC3; two rx_valid pulses; no tx_underrun.
4. Underrun: no tx loaded, select, and send 8'h55 -> miso carries DEFAULT_TX 8'h00, tx_underrun pulses once at ss_fall, rx_data=8'h55.
5. Abort: deassert ss after 5 sclk rising edges.
   - No rx_valid; rx_data unchanged; busy=0 and miso_oe=0 within SYNC_STAGES+1 cycles.
   - The next full word 8'h81 is received correctly.
6. Reset mid-word: assert rst after 4 bits -> outputs return to reset values. The following full transfer of 8'hEA completes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: default word width, idle transmit word and the
// two-state transfer FSM encoding used by both the master and the responders.
package spi_pkg;

    localparam int SPI_WIDTH = 8;
    localparam logic [SPI_WIDTH-1:0] SPI_DEFAULT_TX = 8'h00;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, followed by a registered
// copy that yields single-cycle rise/fall strobes on the synchronised level.
module spi_sync_edge #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{IDLE_LEVEL}};
            prev  <= IDLE_LEVEL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign dout = chain[STAGES-1];
    assign rise = dout & ~prev;
    assign fall = ~dout & prev;

endmodule

// File: rtl/spi_slave_sync.sv
// Fully synchronous SPI mode-0 responder: oversamples sclk/ss/mosi on clk,
// deserialises MOSI into words and serialises a held tx word onto MISO.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int               WIDTH       = SPI_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_TX  = WIDTH'(SPI_DEFAULT_TX),
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             tx_underrun,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
    logic sclk_lvl_unused, ss_lvl_unused, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk),
        .dout(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .din(ss),
        .dout(ss_lvl_unused), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi),
        .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_t       state, state_d;
    logic [WIDTH-1:0] tx_shift, rx_shift, hold_data;
    logic             hold_full;
    logic [CNT_W-1:0] bit_cnt;
    logic             load_tx, shift_tx, shift_rx, clear_cnt, word_done, tx_fire;

    assign tx_ready = ~hold_full;
    assign tx_fire  = tx_valid & ~hold_full;
    assign busy     = (state == ACTIVE);
    assign miso_oe  = (state == ACTIVE);
    assign miso     = miso_oe & tx_shift[WIDTH-1];

    // Deselect outranks any sclk edge; a fall at bit_cnt 0 is a word boundary.
    always_comb begin
        state_d   = state;
        load_tx   = 1'b0;
        shift_tx  = 1'b0;
        shift_rx  = 1'b0;
        clear_cnt = 1'b0;
        word_done = (state == ACTIVE) && (bit_cnt == CNT_W'(WIDTH));
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_d   = ACTIVE;
                    load_tx   = 1'b1;
                    clear_cnt = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d   = IDLE;
                    clear_cnt = 1'b1;
                end else if (sclk_rise) begin
                    shift_rx = 1'b1;
                end else if (sclk_fall) begin
                    if (bit_cnt != '0) shift_tx = 1'b1;
                    else               load_tx  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tx_shift    <= '0;
            rx_shift    <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            bit_cnt     <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            state       <= state_d;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            // A handshake can only land while empty, so a same-cycle load sees the old content.
            if (tx_fire) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end else if (load_tx && hold_full) begin
                hold_full <= 1'b0;
            end

            if (load_tx) begin
                tx_shift    <= hold_full ? hold_data : DEFAULT_TX;
                tx_underrun <= ~hold_full;
            end else if (shift_tx) begin
                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
            end

            if (shift_rx)
                rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};

            if (clear_cnt || word_done)
                bit_cnt <= '0;
            else if (shift_rx)
                bit_cnt <= bit_cnt + CNT_W'(1);

            if (word_done) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: a behavioural mode-0 master at clk/8
// drives the pins while each scenario task checks its own expected values.
module tb_spi_slave_sync;

    logic       clk = 1'b0;
    logic       rst, sclk, ss, mosi;
    logic       miso, miso_oe, tx_valid, tx_ready, rx_valid, tx_underrun, busy;
    logic [7:0] tx_data, rx_data;

    int checks   = 0;
    int failures = 0;
    int rx_cnt   = 0;
    int und_cnt  = 0;
    int miso_hi  = 0;
    logic [7:0] rx_log[$];

    spi_slave_sync dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_cnt++;
            rx_log.push_back(rx_data);
        end
        if (tx_underrun === 1'b1) und_cnt++;
        if (miso === 1'b1) miso_hi++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Shifts the top nbits of mb; with last set, ss rises while sclk is still high.
    task automatic shift_word(input logic [7:0] mb, input int nbits, input bit last,
                              output logic [7:0] sb);
        sb = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = mb[i];
            half();
            sb[i] = miso;
            sclk = 1'b1;
            half();
            if (last && i == 8 - nbits) begin
                ss = 1'b1;
                half();
            end
            sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        int rx0, hi0;
        rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tx_valid = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        checks++; if (miso !== 1'b0) begin failures++; $display("[TB] FAIL reset_miso: got %b expected 0", miso); end
        checks++; if (miso_oe !== 1'b0) begin failures++; $display("[TB] FAIL reset_miso_oe: got %b expected 0", miso_oe); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx_ready: got %b expected 1", tx_ready); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (tx_underrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_underrun: got %b expected 0", tx_underrun); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        rx0 = rx_cnt; hi0 = miso_hi;
        ss = 1'b0; mosi = 1'b1;
        for (int i = 0; i < 16; i++) begin
            repeat (2) @(negedge clk);
            sclk = ~sclk;
        end
        ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (rx_cnt - rx0 !== 0) begin failures++; $display("[TB] FAIL reset_activity_rx: got %0d pulses expected 0", rx_cnt - rx0); end
        checks++; if (miso_hi - hi0 !== 0) begin failures++; $display("[TB] FAIL reset_activity_miso: got %0d high cycles expected 0", miso_hi - hi0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_activity_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        int rx0, u0;
        logic [7:0] r;
        rx0 = rx_cnt; u0 = und_cnt;
        load_tx(8'hA5);
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("[TB] FAIL single_tx_ready_low: got %b expected 0", tx_ready); end
        ss = 1'b0;
        half();
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL single_tx_ready_high: got %b expected 1", tx_ready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
        checks++; if (miso_oe !== 1'b1) begin failures++; $display("[TB] FAIL single_miso_oe: got %b expected 1", miso_oe); end
        shift_word(8'b1110_1010, 8, 1'b1, r);
        half(); half();
        checks++; if (r !== 8'hA5) begin failures++; $display("[TB] FAIL single_miso_word: got %h expected a5", r); end
        checks++; if (rx_data !== 8'hEA) begin failures++; $display("[TB] FAIL single_rx_data: got %h expected ea", rx_data); end
        checks++; if (rx_cnt - rx0 !== 1) begin failures++; $display("[TB] FAIL single_rx_pulses: got %0d expected 1", rx_cnt - rx0); end
        checks++; if (und_cnt - u0 !== 0) begin failures++; $display("[TB] FAIL single_underrun: got %0d expected 0", und_cnt - u0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int rx0, u0;
        logic [7:0] r1, r2;
        rx0 = rx_cnt; u0 = und_cnt;
        load_tx(8'h3C);
        ss = 1'b0;
        half();
        fork
            shift_word(8'h12, 8, 1'b0, r1);
            begin
                repeat (10) @(negedge clk);
                load_tx(8'hC3);
            end
        join
        shift_word(8'h34, 8, 1'b1, r2);
        half(); half();
        checks++; if (r1 !== 8'h3C) begin failures++; $display("[TB] FAIL b2b_word1_miso: got %h expected 3c", r1); end
        checks++; if (r2 !== 8'hC3) begin failures++; $display("[TB] FAIL b2b_word2_miso: got %h expected c3", r2); end
        checks++; if (rx_cnt - rx0 !== 2) begin failures++; $display("[TB] FAIL b2b_rx_pulses: got %0d expected 2", rx_cnt - rx0); end
        checks++; if (und_cnt - u0 !== 0) begin failures++; $display("[TB] FAIL b2b_underrun: got %0d expected 0", und_cnt - u0); end
        if (rx_cnt - rx0 == 2) begin
            checks++; if (rx_log[rx0] !== 8'h12) begin failures++; $display("[TB] FAIL b2b_rx_word1: got %h expected 12", rx_log[rx0]); end
            checks++; if (rx_log[rx0+1] !== 8'h34) begin failures++; $display("[TB] FAIL b2b_rx_word2: got %h expected 34", rx_log[rx0+1]); end
        end
    endtask

    task automatic test_underrun();
        int rx0, u0;
        logic [7:0] r;
        rx0 = rx_cnt; u0 = und_cnt;
        ss = 1'b0;
        half();
        checks++; if (und_cnt - u0 !== 1) begin failures++; $display("[TB] FAIL underrun_at_select: got %0d pulses expected 1", und_cnt - u0); end
        shift_word(8'h55, 8, 1'b1, r);
        half(); half();
        checks++; if (r !== 8'h00) begin failures++; $display("[TB] FAIL underrun_miso_word: got %h expected 00", r); end
        checks++; if (rx_data !== 8'h55) begin failures++; $display("[TB] FAIL underrun_rx_data: got %h expected 55", rx_data); end
        checks++; if (und_cnt - u0 !== 1) begin failures++; $display("[TB] FAIL underrun_total: got %0d pulses expected 1", und_cnt - u0); end
        checks++; if (rx_cnt - rx0 !== 1) begin failures++; $display("[TB] FAIL underrun_rx_pulses: got %0d expected 1", rx_cnt - rx0); end
    endtask

    task automatic test_abort();
        int rx0;
        logic [7:0] r;
        rx0 = rx_cnt;
        ss = 1'b0;
        half();
        load_tx(8'hAB);
        shift_word(8'hF0, 4, 1'b0, r);
        mosi = 1'b1;
        half();
        sclk = 1'b1;
        half();
        ss = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (miso_oe !== 1'b0) begin failures++; $display("[TB] FAIL abort_miso_oe: got %b expected 0", miso_oe); end
        @(negedge clk);
        sclk = 1'b0;
        half(); half();
        checks++; if (rx_cnt - rx0 !== 0) begin failures++; $display("[TB] FAIL abort_rx_pulses: got %0d expected 0", rx_cnt - rx0); end
        checks++; if (rx_data !== 8'h55) begin failures++; $display("[TB] FAIL abort_rx_data: got %h expected 55", rx_data); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("[TB] FAIL abort_hold_kept: got %b expected 0", tx_ready); end
        ss = 1'b0;
        half();
        shift_word(8'h81, 8, 1'b1, r);
        half(); half();
        checks++; if (r !== 8'hAB) begin failures++; $display("[TB] FAIL abort_next_miso: got %h expected ab", r); end
        checks++; if (rx_data !== 8'h81) begin failures++; $display("[TB] FAIL abort_next_rx_data: got %h expected 81", rx_data); end
        checks++; if (rx_cnt - rx0 !== 1) begin failures++; $display("[TB] FAIL abort_next_pulses: got %0d expected 1", rx_cnt - rx0); end
    endtask

    task automatic test_reset_mid_word();
        int rx0, u0;
        logic [7:0] r;
        ss = 1'b0;
        half();
        load_tx(8'h77);
        shift_word(8'hEA, 4, 1'b0, r);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (miso !== 1'b0) begin failures++; $display("[TB] FAIL midrst_miso: got %b expected 0", miso); end
        checks++; if (miso_oe !== 1'b0) begin failures++; $display("[TB] FAIL midrst_miso_oe: got %b expected 0", miso_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_tx_ready: got %b expected 1", tx_ready); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL midrst_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_rx_valid: got %b expected 0", rx_valid); end
        ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rx0 = rx_cnt; u0 = und_cnt;
        load_tx(8'h5A);
        ss = 1'b0;
        half();
        shift_word(8'hEA, 8, 1'b1, r);
        half(); half();
        checks++; if (r !== 8'h5A) begin failures++; $display("[TB] FAIL midrst_next_miso: got %h expected 5a", r); end
        checks++; if (rx_data !== 8'hEA) begin failures++; $display("[TB] FAIL midrst_next_rx_data: got %h expected ea", rx_data); end
        checks++; if (rx_cnt - rx0 !== 1) begin failures++; $display("[TB] FAIL midrst_next_pulses: got %0d expected 1", rx_cnt - rx0); end
        checks++; if (und_cnt - u0 !== 0) begin failures++; $display("[TB] FAIL midrst_next_underrun: got %0d expected 0", und_cnt - u0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_mid_word();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
